// File: rtl/biliner_scale_ctrl_if.sv
// Destination-size request channel of the bilinear scaler configuration controller.
// The requester drives valid/width/height and the controller answers with ready.
interface biliner_scale_ctrl_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] cfg_dst_width;
    logic [11:0] cfg_dst_height;

    modport master (
        output cfg_valid,
        output cfg_dst_width,
        output cfg_dst_height,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_dst_width,
        input  cfg_dst_height,
        output cfg_ready
    );
endinterface

// File: rtl/biliner_scale_ctrl.sv
// Frame-synchronous geometry controller: validates a size request, divides out the
// fixed-point step ratios and commits them on a falling post_img_vsync. Optional: SCALE_CFG_ROUND_EN.
module biliner_scale_ctrl #(
    parameter int C_SRC_IMG_WIDTH  = 640,
    parameter int C_SRC_IMG_HEIGHT = 480,
    parameter int C_MAX_DST_WIDTH  = 3840,
    parameter int C_MAX_DST_HEIGHT = 2160,
    parameter int C_FRAC_BITS      = 16
) (
    input  logic                      clk_in2,
    input  logic                      rst,
    biliner_scale_ctrl_if.slave       cfg,
    input  logic                      post_img_vsync,
    output logic [11:0]               c_dst_img_width,
    output logic [11:0]               c_dst_img_height,
    output logic [12+C_FRAC_BITS-1:0] c_x_ratio,
    output logic [12+C_FRAC_BITS-1:0] c_y_ratio,
    output logic                      cfg_apply,
    output logic                      cfg_err
);

    localparam int RW = 12 + C_FRAC_BITS;
    localparam int CW = $clog2(RW + 1);
    localparam logic [RW-1:0] UNIT_RATIO = RW'(1) << C_FRAC_BITS;

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, PEND} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [11:0]     rem_q, rem_d;
    logic [RW-1:0]   dq_q, dq_d;
    logic [11:0]     cap_w_q, cap_w_d, cap_h_q, cap_h_d;
    logic [RW-1:0]   shd_x_q, shd_x_d, shd_y_q, shd_y_d;
    logic [11:0]     wid_q, wid_d, hgt_q, hgt_d;
    logic [RW-1:0]   xr_q, xr_d, yr_q, yr_d;
    logic            apply_q, apply_d, err_q, err_d;
    logic            vs_q;

    logic            ready_s, illegal_s, fall_s, ge_s;
    logic [12:0]     trial_s, divisor_s;
    logic [RW-1:0]   dq_next_s;
    logic [11:0]     rem_next_s;

    // Fixed-point dividend; the rounding build biases it by half the divisor.
    function automatic logic [RW-1:0] dividend(input int unsigned src, input logic [11:0] d);
        logic [RW-1:0] base;
        base = RW'(src) << C_FRAC_BITS;
`ifdef SCALE_CFG_ROUND_EN
        base = base + RW'(d >> 1);
`else
        base = base + RW'(d & 12'd0);
`endif
        return base;
    endfunction

    assign ready_s   = (state_q == IDLE) && !apply_q;
    assign cfg.cfg_ready = ready_s;
    assign illegal_s = (cfg.cfg_dst_width == 12'd0) || (cfg.cfg_dst_height == 12'd0) ||
                       (cfg.cfg_dst_width > 12'(C_MAX_DST_WIDTH)) ||
                       (cfg.cfg_dst_height > 12'(C_MAX_DST_HEIGHT));
    assign fall_s    = vs_q && !post_img_vsync;

    // Restoring division step: shift in the next dividend bit, subtract when it fits.
    assign divisor_s  = {1'b0, (state_q == DIV_X) ? cap_w_q : cap_h_q};
    assign trial_s    = {rem_q, dq_q[RW-1]};
    assign ge_s       = (trial_s >= divisor_s);
    assign rem_next_s = 12'(ge_s ? (trial_s - divisor_s) : trial_s);
    assign dq_next_s  = {dq_q[RW-2:0], ge_s};

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        cap_w_d = cap_w_q;
        cap_h_d = cap_h_q;
        shd_x_d = shd_x_q;
        shd_y_d = shd_y_q;
        wid_d   = wid_q;
        hgt_d   = hgt_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        apply_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg.cfg_valid && ready_s) begin
                    if (illegal_s) begin
                        err_d = 1'b1;
                    end else begin
                        cap_w_d = cfg.cfg_dst_width;
                        cap_h_d = cfg.cfg_dst_height;
                        cnt_d   = {CW{1'b0}};
                        state_d = DIV_X;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIV_X: begin
                // Count 0 is the operand load; counts 1..RW each retire one quotient bit.
                if (cnt_q == {CW{1'b0}}) begin
                    rem_d = 12'd0;
                    dq_d  = dividend(C_SRC_IMG_WIDTH, cap_w_q);
                    cnt_d = CW'(1);
                end else if (cnt_q == CW'(RW)) begin
                    shd_x_d = dq_next_s;
                    rem_d   = 12'd0;
                    dq_d    = dividend(C_SRC_IMG_HEIGHT, cap_h_q);
                    cnt_d   = CW'(1);
                    state_d = DIV_Y;
                end else begin
                    rem_d = rem_next_s;
                    dq_d  = dq_next_s;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DIV_Y: begin
                rem_d = rem_next_s;
                dq_d  = dq_next_s;
                if (cnt_q == CW'(RW)) begin
                    shd_y_d = dq_next_s;
                    state_d = PEND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PEND: begin
                if (fall_s) begin
                    wid_d   = cap_w_q;
                    hgt_d   = cap_h_q;
                    xr_d    = shd_x_q;
                    yr_d    = shd_y_q;
                    apply_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = PEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and committed-output registers.
    always_ff @(posedge clk_in2 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            rem_q   <= 12'd0;
            dq_q    <= {RW{1'b0}};
            cap_w_q <= 12'(C_SRC_IMG_WIDTH);
            cap_h_q <= 12'(C_SRC_IMG_HEIGHT);
            shd_x_q <= UNIT_RATIO;
            shd_y_q <= UNIT_RATIO;
            wid_q   <= 12'(C_SRC_IMG_WIDTH);
            hgt_q   <= 12'(C_SRC_IMG_HEIGHT);
            xr_q    <= UNIT_RATIO;
            yr_q    <= UNIT_RATIO;
            apply_q <= 1'b0;
            err_q   <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            cap_w_q <= cap_w_d;
            cap_h_q <= cap_h_d;
            shd_x_q <= shd_x_d;
            shd_y_q <= shd_y_d;
            wid_q   <= wid_d;
            hgt_q   <= hgt_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            apply_q <= apply_d;
            err_q   <= err_d;
            vs_q    <= post_img_vsync;
        end
    end

    assign c_dst_img_width  = wid_q;
    assign c_dst_img_height = hgt_q;
    assign c_x_ratio        = xr_q;
    assign c_y_ratio        = yr_q;
    assign cfg_apply        = apply_q;
    assign cfg_err          = err_q;

endmodule
